color_sense_frontend: RTL and testbench



---
 rtl/color_sense_frontend.sv | 231 +++++++++++++++++++++++
 tb/tb_color_sense_frontend.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_sense_frontend.sv
// color_sense_frontend: I2C master that initialises and polls an RGB
// light sensor at 0x29, plus the SCL timebase and a one-shot settle timer.
module color_sense_frontend #(
  parameter int unsigned HALF_DIV     = 63,
  parameter logic [7:0]  ATIME_VAL    = 8'hF6,
  parameter int unsigned DELAY_CYCLES = 2_500_000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         scl,
  inout  wire         sda,
  output logic [47:0] value,
  output logic        value_valid,
  output logic        nack_error,
  input  logic        timer_start,
  output logic        timer_done
);

  localparam int unsigned DW = $clog2(HALF_DIV) + 1;
  localparam int unsigned TW = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [1:0] {
    T_INIT1,
    T_INIT2,
    T_READ
  } txn_e;

  typedef enum logic [2:0] {
    PH_START,
    PH_BIT,
    PH_PRE,
    PH_P1,
    PH_P2,
    PH_IDLE
  } ph_e;

  logic [DW-1:0] div_q;
  logic          slow_q;
  logic          fall_q;
  logic          tick;
  logic          rise;
  logic          fall;

  txn_e          txn_q;
  ph_e           ph_q;
  logic [3:0]    idx_q;
  logic [3:0]    bit_q;
  logic [7:0]    rx_q;
  logic          err_q;
  logic          scl_oe_q;
  logic          sda_oe_q;
  logic [7:0]    rd_q [6];
  logic [47:0]   value_q;
  logic          valid_q;
  logic          nack_q;

  logic [7:0]    cur_byte;
  logic          is_rd;
  logic          last_byte;
  logic          sda_drive;
  logic          sda_in;

  logic [TW-1:0] tcnt_q;
  logic          trun_q;
  logic          tdone_q;

  assign tick = (div_q == DW'(HALF_DIV - 1));
  assign rise = tick & ~slow_q;
  assign fall = tick & slow_q;

  assign scl = scl_oe_q ? 1'b0 : 1'bz;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign value       = value_q;
  assign value_valid = valid_q;
  assign nack_error  = nack_q;
  assign timer_done  = tdone_q;

  always_comb begin
    cur_byte = 8'h52;
    if (idx_q == 4'd1) begin
      unique case (txn_q)
        T_INIT1: cur_byte = 8'h80;
        T_INIT2: cur_byte = 8'h81;
        default: cur_byte = 8'hB6;
      endcase
    end else if (idx_q == 4'd2) begin
      unique case (txn_q)
        T_INIT1: cur_byte = 8'h03;
        T_INIT2: cur_byte = ATIME_VAL;
        default: cur_byte = 8'h53;
      endcase
    end
  end

  // bytes 3..8 of a READ are sensor data; bit 8 is the ACK slot
  assign is_rd = (txn_q == T_READ) && (idx_q >= 4'd3);
  assign last_byte = (txn_q == T_READ) ? (idx_q == 4'd8)
                                       : (idx_q == 4'd2);
  assign sda_drive = (bit_q == 4'd8)
    ? (is_rd && (idx_q != 4'd8))
    : (!is_rd && !cur_byte[3'(4'd7 - bit_q)]);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q    <= '0;
      slow_q   <= 1'b0;
      fall_q   <= 1'b0;
      txn_q    <= T_INIT1;
      ph_q     <= PH_START;
      idx_q    <= '0;
      bit_q    <= '0;
      rx_q     <= '0;
      err_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      nack_q   <= 1'b0;
      for (int i = 0; i < 6; i++) rd_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      nack_q  <= 1'b0;
      fall_q  <= fall;
      div_q   <= tick ? '0 : div_q + DW'(1);
      if (tick) slow_q <= ~slow_q;

      if (fall && (ph_q inside {PH_BIT, PH_PRE, PH_P1}))
        scl_oe_q <= 1'b1;

      // SDA moves one clock after SCL falls, well inside the low phase
      if (fall_q) begin
        unique case (ph_q)
          PH_BIT:  sda_oe_q <= sda_drive;
          PH_PRE:  sda_oe_q <= 1'b0;
          PH_P1:   sda_oe_q <= 1'b1;
          default: ;
        endcase
      end

      if (rise) begin
        unique case (ph_q)
          PH_START: begin
            sda_oe_q <= 1'b1;
            ph_q     <= PH_BIT;
            bit_q    <= '0;
            err_q    <= 1'b0;
          end
          PH_BIT: begin
            scl_oe_q <= 1'b0;
            if (bit_q != 4'd8) begin
              bit_q <= bit_q + 4'd1;
              rx_q  <= {rx_q[6:0], sda_in};
              if (is_rd && bit_q == 4'd7)
                rd_q[3'(idx_q - 4'd3)] <= {rx_q[6:0], sda_in};
            end else begin
              bit_q <= '0;
              if (!is_rd && sda_in) begin
                nack_q <= 1'b1;
                err_q  <= 1'b1;
                txn_q  <= T_INIT1;
                ph_q   <= PH_P1;
              end else if (last_byte) begin
                ph_q <= PH_P1;
              end else if (txn_q == T_READ && idx_q == 4'd1) begin
                ph_q  <= PH_PRE;
                idx_q <= 4'd2;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          PH_PRE: begin
            scl_oe_q <= 1'b0;
            ph_q     <= PH_START;
          end
          PH_P1: begin
            scl_oe_q <= 1'b0;
            ph_q     <= PH_P2;
          end
          PH_P2: begin
            sda_oe_q <= 1'b0;
            idx_q    <= '0;
            if (err_q) begin
              ph_q <= PH_IDLE;
            end else begin
              unique case (txn_q)
                T_INIT1: begin
                  txn_q <= T_INIT2;
                  ph_q  <= PH_START;
                end
                T_INIT2: begin
                  txn_q <= T_READ;
                  ph_q  <= PH_START;
                end
                default: begin
                  value_q <= {rd_q[5], rd_q[4], rd_q[1],
                              rd_q[0], rd_q[3], rd_q[2]};
                  valid_q <= 1'b1;
                  ph_q    <= PH_IDLE;
                end
              endcase
            end
          end
          default: ph_q <= PH_START;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q  <= '0;
      trun_q  <= 1'b0;
      tdone_q <= 1'b0;
    end else if (timer_start) begin
      tcnt_q  <= TW'(DELAY_CYCLES - 1);
      trun_q  <= 1'b1;
      tdone_q <= 1'b0;
    end else if (trun_q) begin
      if (tcnt_q == '0) begin
        trun_q  <= 1'b0;
        tdone_q <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_color_sense_frontend.sv
// tb_color_sense_frontend: I2C slave model with token scoreboard,
// value/NACK tracking and a table-driven settle-timer check.
module tb_color_sense_frontend;
  localparam int HD = 8;
  localparam int DC = 10;
  localparam logic [8:0] TS = 9'h100;
  localparam logic [8:0] TP = 9'h101;
  localparam logic [8:0] TA = 9'h102;
  localparam logic [8:0] TN = 9'h103;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        timer_start = 1'b0;
  wire         scl;
  wire         sda;
  logic [47:0] value;
  logic        value_valid;
  logic        nack_error;
  logic        timer_done;

  logic sl_low = 1'b0;
  pullup (scl);
  pullup (sda);
  assign sda = sl_low ? 1'b0 : 1'bz;

  color_sense_frontend #(
    .HALF_DIV(HD),
    .ATIME_VAL(8'hF6),
    .DELAY_CYCLES(DC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .scl(scl),
    .sda(sda),
    .value(value),
    .value_valid(value_valid),
    .nack_error(nack_error),
    .timer_start(timer_start),
    .timer_done(timer_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [8:0]  exp_q [$];
  logic [47:0] vexp_q [$];
  int valid_cnt = 0;
  int nack_cnt = 0;
  logic nack_mode = 1'b0;
  logic [7:0] rd_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  int cyc = 0;
  int last_rise = 0;
  int bitcnt = 0;
  int byte_n = 0;
  logic active = 1'b0;
  logic rd_mode = 1'b0;
  logic mack = 1'b0;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;
  logic [7:0] sh = '0;
  int per_min = 1000000;
  int per_max = 0;
  int hi_min = 1000000;
  int hi_max = 0;

  typedef struct {
    logic start;
    logic done;
  } tstep_t;
  tstep_t tv [$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic tok(input logic [8:0] t);
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e !== t) begin
        failures++;
        $display("FAIL bus_token got=%h want=%h", t, e);
      end
    end
  endtask

  always @(negedge clock) begin
    logic s, d;
    logic [47:0] ve;
    s = scl;
    d = sda;
    cyc++;
    if (value_valid) begin
      valid_cnt++;
      if (vexp_q.size() > 0) begin
        ve = vexp_q.pop_front();
        checks++;
        if (value !== ve) begin
          failures++;
          $display("FAIL value got=%h want=%h", value, ve);
        end
      end
    end
    if (nack_error) nack_cnt++;
    if (p_scl && s && p_sda && !d) begin
      active = 1'b1;
      bitcnt = 0;
      byte_n = 0;
      rd_mode = 1'b0;
      sl_low <= 1'b0;
      tok(TS);
    end else if (p_scl && s && !p_sda && d) begin
      active = 1'b0;
      sl_low <= 1'b0;
      tok(TP);
    end else if (active && !p_scl && s) begin
      if (!reset && bitcnt >= 1) begin
        per_min = (cyc - last_rise < per_min) ? cyc - last_rise : per_min;
        per_max = (cyc - last_rise > per_max) ? cyc - last_rise : per_max;
      end
      last_rise = cyc;
      if (bitcnt < 8) begin
        sh = {sh[6:0], d};
        if (bitcnt == 7) begin
          tok({1'b0, sh});
          if (byte_n == 0) rd_mode = d;
        end
        bitcnt++;
      end else begin
        if (rd_mode && byte_n > 0) tok(d ? TN : TA);
        mack = !d;
        bitcnt = 0;
        byte_n++;
      end
    end else if (active && p_scl && !s) begin
      if (!reset && bitcnt >= 1) begin
        hi_min = (cyc - last_rise < hi_min) ? cyc - last_rise : hi_min;
        hi_max = (cyc - last_rise > hi_max) ? cyc - last_rise : hi_max;
      end
      if (bitcnt == 8)
        sl_low <= (!rd_mode || byte_n == 0) && !(nack_mode && byte_n == 0);
      else if (rd_mode && byte_n >= 1 && byte_n <= 6 && (byte_n == 1 || mack))
        sl_low <= !rd_data[byte_n-1][7-bitcnt];
      else
        sl_low <= 1'b0;
    end
    p_scl = s;
    p_sda = d;
  end

  task automatic push_init1();
    exp_q.push_back(TS); exp_q.push_back(9'h052);
    exp_q.push_back(9'h080); exp_q.push_back(9'h003);
    exp_q.push_back(TP);
  endtask

  task automatic push_init2();
    exp_q.push_back(TS); exp_q.push_back(9'h052);
    exp_q.push_back(9'h081); exp_q.push_back(9'h0F6);
    exp_q.push_back(TP);
  endtask

  task automatic push_read();
    exp_q.push_back(TS); exp_q.push_back(9'h052);
    exp_q.push_back(9'h0B6); exp_q.push_back(TS);
    exp_q.push_back(9'h053);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, rd_data[i]});
      exp_q.push_back(i == 5 ? TN : TA);
    end
    exp_q.push_back(TP);
    vexp_q.push_back(48'h6655_2211_4433);
  endtask

  task automatic wait_exp(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || vexp_q.size() > 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() > 0 || vexp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout left=%0d want=0", nm,
               exp_q.size() + vexp_q.size());
      exp_q.delete();
      vexp_q.delete();
    end
  endtask

  initial begin
    repeat (5) @(negedge clock);
    chk("rst_scl", 64'(scl), 1);
    chk("rst_sda", 64'(sda), 1);
    chk("rst_value", value, 0);
    chk("rst_valid", 64'(value_valid), 0);
    chk("rst_nack", 64'(nack_error), 0);
    chk("rst_tdone", 64'(timer_done), 0);

    reset = 1'b0;
    push_init1();
    push_init2();
    push_read();
    wait_exp("init_read", 8000);
    chk("valid_cnt1", 64'(valid_cnt), 1);
    chk("value1", value, 48'h6655_2211_4433);
    chk("nack_cnt0", 64'(nack_cnt), 0);

    push_read();
    wait_exp("read2", 4000);
    chk("valid_cnt2", 64'(valid_cnt), 2);

    exp_q.push_back(TS);
    exp_q.push_back(9'h052);
    wait_exp("read3_addr", 4000);
    repeat (6 * HD) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_scl", 64'(scl), 1);
    chk("midrst_sda", 64'(sda), 1);
    chk("midrst_value", value, 0);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    push_init1();
    push_init2();
    wait_exp("reinit", 4000);
    chk("reinit_value", value, 0);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    nack_mode = 1'b1;
    nack_cnt = 0;
    reset = 1'b0;
    exp_q.push_back(TS);
    exp_q.push_back(9'h052);
    exp_q.push_back(TP);
    wait_exp("nack_seq", 4000);
    chk("nack_pulse", 64'(nack_cnt), 1);
    nack_mode = 1'b0;
    push_init1();
    wait_exp("after_nack", 4000);
    chk("nack_cnt_after", 64'(nack_cnt), 1);
    chk("nack_value", value, 0);

    for (int k = 0; k < 12; k++)
      tv.push_back('{start: (k == 0), done: (k >= 10)});
    for (int k = 0; k < 17; k++)
      tv.push_back('{start: (k == 0 || k == 5), done: (k >= 15)});
    for (int k = 0; k < 15; k++)
      tv.push_back('{start: (k <= 3), done: (k >= 13)});
    for (int i = 0; i < tv.size(); i++) begin
      timer_start = tv[i].start;
      @(negedge clock);
      chk($sformatf("timer_step%0d", i), 64'(timer_done), 64'(tv[i].done));
    end
    timer_start = 1'b0;

    chk("scl_period_min", 64'(per_min), 2 * HD);
    chk("scl_period_max", 64'(per_max), 2 * HD);
    chk("scl_high_min", 64'(hi_min), HD);
    chk("scl_high_max", 64'(hi_max), HD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
